// File: rtl/vga_timing_gen.sv
`default_nettype none
// =============================================================================
// Module   : vga_timing_gen
// Brief    : 800x600@72 raster timing with delayed syncs and vblank update grant.
//            Define FRAME_COUNTER_EN to add the o_frame_cnt output.
// Revision : 1.0
// =============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int PIPE_DLY = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        o_active,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_line,
    output logic        o_frame,
    input  logic        i_upd_req,
    output logic        o_upd_gnt
`ifdef FRAME_COUNTER_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_W   = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT_W   = 10'(V_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] x_nxt;
    logic [9:0]  y_nxt;
    logic        hs_raw;
    logic        vs_raw;
    logic        granted;

    always_comb begin
        x_nxt = x + 11'd1;
        y_nxt = y;
        if (x == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y == V_LAST) ? '0 : y + 10'd1;
        end
    end

    // Everything is registered from the next position so it lines up with x/y.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x         <= '0;
            y         <= '0;
            o_active  <= 1'b0;
            o_line    <= 1'b0;
            o_frame   <= 1'b0;
            hs_raw    <= ~H_POL;
            vs_raw    <= ~V_POL;
            granted   <= 1'b0;
            o_upd_gnt <= 1'b0;
        end else begin
            x        <= x_nxt;
            y        <= y_nxt;
            o_active <= (x_nxt < H_ACT_W) && (y_nxt < V_ACT_W);
            o_line   <= (x_nxt == '0);
            o_frame  <= (x_nxt == '0) && (y_nxt == V_ACT_W);
            hs_raw   <= (x_nxt >= HS_START && x_nxt < HS_END) ? H_POL : ~H_POL;
            vs_raw   <= (y_nxt >= VS_START && y_nxt < VS_END) ? V_POL : ~V_POL;

            // One grant per frame; the flag re-arms when the raster wraps to the top.
            if (x_nxt == '0 && y_nxt == '0) begin
                granted   <= 1'b0;
                o_upd_gnt <= 1'b0;
            end else if (!i_upd_req) begin
                o_upd_gnt <= 1'b0;
            end else if (y_nxt >= V_ACT_W && !granted) begin
                o_upd_gnt <= 1'b1;
                granted   <= 1'b1;
            end
        end
    end

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign o_hsync = hs_raw;
            assign o_vsync = vs_raw;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_pipe;
            logic [PIPE_DLY-1:0] vs_pipe;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    hs_pipe <= {PIPE_DLY{~H_POL}};
                    vs_pipe <= {PIPE_DLY{~V_POL}};
                end else begin
                    hs_pipe[0] <= hs_raw;
                    vs_pipe[0] <= vs_raw;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        hs_pipe[i] <= hs_pipe[i-1];
                        vs_pipe[i] <= vs_pipe[i-1];
                    end
                end
            end

            assign o_hsync = hs_pipe[PIPE_DLY-1];
            assign o_vsync = vs_pipe[PIPE_DLY-1];
        end
    endgenerate

`ifdef FRAME_COUNTER_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_frame_cnt <= '0;
        end else if (x_nxt == '0 && y_nxt == V_ACT_W) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// =============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench: full-size timing literals plus a reduced-size
//            instance compared every cycle against an arithmetic raster model.
// Revision : 1.0
// =============================================================================
module tb_vga_timing_gen;

    // Reduced raster so several whole frames fit in a short run.
    localparam int HA = 20, HF = 3, HS = 5, HB = 4;
    localparam int VA = 10, VF = 2, VS = 3, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int P  = 2;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, req0, req1;
    logic [10:0] x0, x1;
    logic [9:0]  y0, y1;
    logic        act0, act1, hs0, hs1, vs0, vs1, line0, line1, frame0, frame1, gnt0, gnt1;
`ifdef FRAME_COUNTER_EN
    logic [15:0] fc0, fc1;
`endif

    int checks = 0;
    int errors = 0;

    vga_timing_gen d0 (
        .clk(clk), .rst(rst0), .x(x0), .y(y0), .o_active(act0),
        .o_hsync(hs0), .o_vsync(vs0), .o_line(line0), .o_frame(frame0),
        .i_upd_req(req0), .o_upd_gnt(gnt0)
`ifdef FRAME_COUNTER_EN
        , .o_frame_cnt(fc0)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(HPOL), .V_POL(VPOL), .PIPE_DLY(P)
    ) d1 (
        .clk(clk), .rst(rst1), .x(x1), .y(y1), .o_active(act1),
        .o_hsync(hs1), .o_vsync(vs1), .o_line(line1), .o_frame(frame1),
        .i_upd_req(req1), .o_upd_gnt(gnt1)
`ifdef FRAME_COUNTER_EN
        , .o_frame_cnt(fc1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model for d1 (position = f(cycles since reset))
    function automatic int px(input int s);
        return s % HT;
    endfunction
    function automatic int py(input int s);
        return (s / HT) % VT;
    endfunction
    function automatic bit raw_h(input int s);
        return (px(s) >= HA + HF && px(s) < HA + HF + HS) ? HPOL : !HPOL;
    endfunction
    function automatic bit raw_v(input int s);
        return (py(s) >= VA + VF && py(s) < VA + VF + VS) ? VPOL : !VPOL;
    endfunction
    function automatic int exp_fc(input int s);
        return (s < VA * HT) ? 0 : (((s - VA * HT) / FT + 1) & 16'hFFFF);
    endfunction

    bit mvalid   = 1'b0;
    int t        = 0;
    bit m_gnt    = 1'b0;
    int last_fid = -1;

    always @(posedge clk) begin
        if (rst1 === 1'b0) begin
            mvalid   <= 1'b1;
            t        <= 0;
            m_gnt    <= 1'b0;
            last_fid <= -1;
        end else if (mvalid) begin
            t <= t + 1;
            if (req1 && py(t + 1) >= VA && (m_gnt || last_fid != (t + 1) / FT)) begin
                m_gnt    <= 1'b1;
                last_fid <= (t + 1) / FT;
            end else begin
                m_gnt <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_x", x1, px(t));
            chk("m_y", y1, py(t));
            chk("m_active", act1, (t > 0 && px(t) < HA && py(t) < VA) ? 1 : 0);
            chk("m_line", line1, (t > 0 && px(t) == 0) ? 1 : 0);
            chk("m_frame", frame1, (px(t) == 0 && py(t) == VA) ? 1 : 0);
            chk("m_hsync", hs1, (t >= P) ? raw_h(t - P) : !HPOL);
            chk("m_vsync", vs1, (t >= P) ? raw_v(t - P) : !VPOL);
            chk("m_gnt", gnt1, m_gnt);
`ifdef FRAME_COUNTER_EN
            chk("m_frame_cnt", fc1, exp_fc(t));
`endif
        end
    end

    task automatic wait_xy1(input int wx, input int wy, input string nm);
        int n = 0;
        while (!(x1 == 11'(wx) && y1 == 10'(wy)) && n < 4 * FT) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (n < 4 * FT) ? 1 : 0, 1);
    endtask

    initial begin
        int n;
`ifdef FRAME_COUNTER_EN
        logic [15:0] fc_a;
`endif
        rst0 = 1'b0; rst1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // ---------------- full-size instance: reset state and line timing
        chk("rst_x", x0, 0);
        chk("rst_y", y0, 0);
        chk("rst_active", act0, 0);
        chk("rst_hsync", hs0, 0);
        chk("rst_vsync", vs0, 0);
        chk("rst_line", line0, 0);
        chk("rst_frame", frame0, 0);
        chk("rst_gnt", gnt0, 0);
        rst0 = 1'b1; rst1 = 1'b1;
        @(negedge clk);
        chk("first_x", x0, 1);
        chk("first_active", act0, 1);

        n = 0;
        while (!(x0 == 11'd799 && y0 == 10'd10) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_799_10", (n < 20000) ? 1 : 0, 1);
        @(negedge clk);
        chk("x_800", x0, 800);
        chk("active_off_800", act0, 0);

        n = 0;
        while (hs0 !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("hsync_rise_x", x0, 858);
        chk("hsync_rise_y", y0, 10);
        n = 0;
        while (hs0 === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("hsync_width", n, 120);
        chk("hsync_fall_x", x0, 978);

        // ---------------- reduced instance: update handshake
        wait_xy1(0, 5, "reach_y5");
        req1 = 1'b1;
        n = 0;
        while (gnt1 !== 1'b1 && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_rise_x", x1, 0);
        chk("gnt_rise_y", y1, VA);
        wait_xy1(0, VA + 1, "reach_drop");
        req1 = 1'b0;
        @(negedge clk);
        chk("gnt_drop", gnt1, 0);
        wait_xy1(0, VA + 2, "reach_reraise");
        req1 = 1'b1;
        n = 0;
        while (gnt1 !== 1'b1 && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        chk("regrant_gap", n, (VT - 2) * HT);
        chk("regrant_y", y1, VA);

        // mid-frame reset while granted and with hsync asserted
        wait_xy1(25, VA + 1, "reach_midrst");
        chk("pre_rst_hsync", hs1, HPOL);
        rst1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        chk("midrst_x", x1, 0);
        chk("midrst_y", y1, 0);
        chk("midrst_gnt", gnt1, 0);
        chk("midrst_hsync", hs1, !HPOL);
        @(negedge clk);
        chk("midrst_hsync2", hs1, !HPOL);

        // frame pulse spacing
        n = 0;
        while (frame1 !== 1'b1 && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        chk("frame_with_line", line1, 1);
`ifdef FRAME_COUNTER_EN
        fc_a = fc1;
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame1 !== 1'b1 && n < 2 * FT);
        chk("frame_period", n, FT);
`ifdef FRAME_COUNTER_EN
        chk("frame_cnt_step", fc1, fc_a + 16'd1);
`endif

        // ---------------- randomized requests and occasional resets
        req1 = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) req1 = ~req1;
            rst1 = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
        end
        rst1 = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
